// File: rtl/reg_serial_out.sv
// ---------------------------------------------------------------------------
// reg_serial_out
//   Snapshots the register bank word on a start request and shifts it out
//   one bit per accepted beat over a valid/ready serial handshake.
//
// Ports
//   clk         : clock, all state updates on the rising edge
//   reset       : asynchronous, active-high reset
//   q_in        : register bank contents, sampled only on the accept cycle
//   start       : request to send the current q_in (accepted when ready)
//   ready       : high in IDLE
//   busy        : high while a frame is in progress (SHIFT, PAR, DONE)
//   sout        : current serial bit, 0 whenever sout_valid is low
//   sout_valid  : sout holds a valid bit
//   sout_ready  : consumer takes the bit when sout_valid & sout_ready
//   done        : one-cycle pulse after the last bit is taken
//
// Configuration
//   REG_SERIAL_OUT_PARITY_EN : when defined, an even-parity bit (XOR of the
//   captured word) is sent as an extra beat after the data bits.
// ---------------------------------------------------------------------------
module reg_serial_out #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] q_in,
    input  logic             start,
    output logic             ready,
    output logic             busy,
    output logic             sout,
    output logic             sout_valid,
    input  logic             sout_ready,
    output logic             done
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    bitcnt;
    logic             beat;
    logic             last_bit;

`ifdef REG_SERIAL_OUT_PARITY_EN
    logic             par_bit;
`endif

    assign beat     = sout_valid & sout_ready;
    assign last_bit = (bitcnt == CW'(WIDTH - 1));

    // Bit that goes out first from a freshly captured word.
    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return LSB_FIRST ? w[0] : w[WIDTH-1];
    endfunction

    // sout is registered: it is loaded with the bit that will sit at the
    // sending end of shreg after the capture or shift takes effect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            shreg      <= '0;
            bitcnt     <= '0;
            ready      <= 1'b1;
            busy       <= 1'b0;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            done       <= 1'b0;
`ifdef REG_SERIAL_OUT_PARITY_EN
            par_bit    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= SHIFT;
                        shreg      <= q_in;
                        bitcnt     <= '0;
                        ready      <= 1'b0;
                        busy       <= 1'b1;
                        sout_valid <= 1'b1;
                        sout       <= first_bit(q_in);
`ifdef REG_SERIAL_OUT_PARITY_EN
                        par_bit    <= ^q_in;
`endif
                    end
                end

                SHIFT: begin
                    if (beat) begin
                        shreg  <= LSB_FIRST ? (shreg >> 1) : (shreg << 1);
                        bitcnt <= bitcnt + CW'(1);
                        if (last_bit) begin
`ifdef REG_SERIAL_OUT_PARITY_EN
                            state      <= PAR;
                            sout       <= par_bit;
`else
                            state      <= DONE;
                            sout       <= 1'b0;
                            sout_valid <= 1'b0;
                            done       <= 1'b1;
`endif
                        end else begin
                            sout <= LSB_FIRST ? shreg[1] : shreg[WIDTH-2];
                        end
                    end
                end

`ifdef REG_SERIAL_OUT_PARITY_EN
                PAR: begin
                    if (beat) begin
                        state      <= DONE;
                        sout       <= 1'b0;
                        sout_valid <= 1'b0;
                        done       <= 1'b1;
                    end
                end
`endif

                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    ready <= 1'b1;
                end

                default: begin
                    state      <= IDLE;
                    ready      <= 1'b1;
                    busy       <= 1'b0;
                    sout       <= 1'b0;
                    sout_valid <= 1'b0;
                    done       <= 1'b0;
                end
            endcase
        end
    end

endmodule
